// File: rtl/digit_scan_ctrl_pkg.sv
// Shared definitions for the seven-segment display blocks: scan FSM state codes
// and a constant-width helper.
package digit_scan_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2
    } scan_state_t;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        int unsigned x;
        r = 0;
        x = (v > 0) ? v - 1 : 0;
        while (x > 0) begin
            r++;
            x = x >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/digit_scan_ctrl_demux.sv
// Active-low one-hot decoder: the inverse of the digit-data MUX, driving one
// anode low for the selected digit when enabled.
module demux_onehot #(
    parameter int unsigned S = 2
) (
    input  logic [S-1:0]      i_sel,
    input  logic              i_en,
    output logic [2**S-1:0]   o_an
);

    always_comb begin
        o_an = '1;
        if (i_en) begin
            o_an[i_sel] = 1'b0;
        end
    end

endmodule

// File: rtl/digit_scan_ctrl.sv
// Seven-segment scan controller: cycles sel across 2**S digits, shows each for
// CLK_DIV clocks, and inserts a BLANK-clock all-off gap between digits.
module digit_scan_ctrl
    import digit_scan_ctrl_pkg::*;
#(
    parameter int unsigned S       = 2,
    parameter int unsigned CLK_DIV = 50000,
    parameter int unsigned BLANK   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [2**S-1:0]   blank_mask,
    output logic [S-1:0]      sel,
    output logic [2**S-1:0]   an,
    output logic              frame_start
);

    localparam int unsigned PW = (clog2(CLK_DIV) > 0) ? clog2(CLK_DIV) : 1;
    localparam int unsigned GW = (clog2(BLANK + 1) > 0) ? clog2(BLANK + 1) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(CLK_DIV - 1);
    localparam logic [GW-1:0] G_LAST = GW'((BLANK > 0) ? BLANK - 1 : 0);

    scan_state_t     r_state, w_state_nxt;
    logic [S-1:0]    r_sel, w_sel_nxt, w_sel_inc;
    logic [PW-1:0]   r_pre, w_pre_nxt;
    logic [GW-1:0]   r_gap, w_gap_nxt;
    logic            r_fs, w_fs_nxt;
    logic            w_show_en;

    assign w_sel_inc = r_sel + S'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_sel   <= '0;
            r_pre   <= '0;
            r_gap   <= '0;
            r_fs    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_pre   <= w_pre_nxt;
            r_gap   <= w_gap_nxt;
            r_fs    <= w_fs_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_pre_nxt   = r_pre;
        w_gap_nxt   = r_gap;
        w_fs_nxt    = 1'b0;
        if (!en) begin
            w_state_nxt = IDLE;
            w_sel_nxt   = '0;
            w_pre_nxt   = '0;
            w_gap_nxt   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_nxt = SHOW;
                    w_sel_nxt   = '0;
                    w_pre_nxt   = '0;
                    w_fs_nxt    = 1'b1;
                end
                SHOW: begin
                    if (r_pre == P_LAST) begin
                        // sel advances as the slot ends so MUX data settles during the gap
                        w_sel_nxt = w_sel_inc;
                        w_pre_nxt = '0;
                        w_gap_nxt = '0;
                        if (BLANK > 0) begin
                            w_state_nxt = GAP;
                        end else begin
                            w_state_nxt = SHOW;
                            w_fs_nxt    = (w_sel_inc == '0);
                        end
                    end else begin
                        w_pre_nxt = r_pre + PW'(1);
                    end
                end
                GAP: begin
                    if (r_gap == G_LAST) begin
                        w_state_nxt = SHOW;
                        w_gap_nxt   = '0;
                        w_pre_nxt   = '0;
                        w_fs_nxt    = (r_sel == '0);
                    end else begin
                        w_gap_nxt = r_gap + GW'(1);
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_sel_nxt   = '0;
                    w_pre_nxt   = '0;
                    w_gap_nxt   = '0;
                end
            endcase
        end
    end

    assign w_show_en   = (r_state == SHOW) && !blank_mask[r_sel];
    assign sel         = r_sel;
    assign frame_start = r_fs;

    demux_onehot #(.S(S)) u_demux (
        .i_sel (r_sel),
        .i_en  (w_show_en),
        .o_an  (an)
    );

endmodule
